// File: rtl/aes_ctrl_pkg.sv
// Shared types for the AES encryption-core arbiter: FSM states, requester ID,
// 128-bit block type, default timeout and a small ID-to-mask helper.
package aes_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } arb_state_e;

    typedef logic         req_id_t;
    typedef logic [127:0] block_t;

    localparam int unsigned DefaultTimeoutCycles = 1000;

    // One-hot mask for a requester ID.
    function automatic logic [1:0] id_to_mask(input req_id_t id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/aes_enc_arbiter_if.sv
// Requester and AES-core signal bundle for aes_enc_arbiter.
// slave: the arbiter's view. master: requesters plus core, i.e. everything around it.
interface aes_enc_arbiter_if;
    import aes_ctrl_pkg::*;

    logic [1:0] req_valid;
    logic [1:0] req_ready;
    block_t     req0_data;
    block_t     req1_data;
    block_t     req0_key;
    block_t     req1_key;
    logic [1:0] resp_valid;
    logic [1:0] resp_ready;
    block_t     resp_data;
    logic       resp_err;
    logic       core_valid_out;
    block_t     core_data_out;
    block_t     core_key_out;
    block_t     core_res_in;
    logic       core_res_valid_in;

    modport slave (
        input  req_valid, req0_data, req1_data, req0_key, req1_key, resp_ready,
        input  core_res_in, core_res_valid_in,
        output req_ready, resp_valid, resp_data, resp_err,
        output core_valid_out, core_data_out, core_key_out
    );

    modport master (
        output req_valid, req0_data, req1_data, req0_key, req1_key, resp_ready,
        output core_res_in, core_res_valid_in,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  core_valid_out, core_data_out, core_key_out
    );

endinterface

// File: rtl/aes_rr_arbiter.sv
// Two-way round-robin grant: on contention the requester not granted last wins,
// a lone requester always wins.
module aes_rr_arbiter
    import aes_ctrl_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_t    last,
    input  logic       en,
    output req_id_t    grant_id,
    output logic       grant_vld
);

    // Pick the winner from the current valid pattern and grant history.
    always_comb begin
        grant_id = 1'b0;
        case (valid)
            2'b11:   grant_id = ~last;
            2'b10:   grant_id = 1'b1;
            default: grant_id = 1'b0;
        endcase
    end

    assign grant_vld = en && (valid != 2'b00);

endmodule

// File: rtl/aes_enc_arbiter.sv
// Shares one AES encryption core between two requesters, one request in flight.
// Optional WAIT timeout enabled by defining AES_ARB_TIMEOUT_EN; otherwise WAIT is
// unbounded and resp_err is constant 0.
module aes_enc_arbiter
    import aes_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
    input logic              clk,
    input logic              resetn,
    aes_enc_arbiter_if.slave bus
);

    arb_state_e state_q;
    req_id_t    last_q;
    req_id_t    owner_q;
    req_id_t    grant_id;
    logic       grant_vld;
    logic       arb_en;
    logic [1:0] req_ready;
    logic       core_valid_q;
    block_t     core_data_q;
    block_t     core_key_q;
    block_t     resp_data_q;
    logic [1:0] resp_valid_q;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("aes_enc_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef AES_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q;
    logic            err_q;

    assign bus.resp_err = err_q;
`else
    assign bus.resp_err = 1'b0;
`endif

    // Grants are only offered while idle; gating with resetn keeps req_ready low in reset.
    assign arb_en = (state_q == StIdle) && resetn;

    aes_rr_arbiter u_rr (
        .valid     (bus.req_valid),
        .last      (last_q),
        .en        (arb_en),
        .grant_id  (grant_id),
        .grant_vld (grant_vld)
    );

    // Single-cycle accept strobe to the granted requester only.
    always_comb begin
        req_ready = 2'b00;
        if (grant_vld) begin
            req_ready = id_to_mask(grant_id);
        end
    end

    assign bus.req_ready      = req_ready;
    assign bus.core_valid_out = core_valid_q;
    assign bus.core_data_out  = core_data_q;
    assign bus.core_key_out   = core_key_q;
    assign bus.resp_data      = resp_data_q;
    assign bus.resp_valid     = resp_valid_q;

    // Request FSM with registered core and response outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            last_q       <= 1'b1;
            owner_q      <= 1'b0;
            core_valid_q <= 1'b0;
            core_data_q  <= '0;
            core_key_q   <= '0;
            resp_data_q  <= '0;
            resp_valid_q <= 2'b00;
`ifdef AES_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            core_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (grant_vld) begin
                        owner_q      <= grant_id;
                        last_q       <= grant_id;
                        core_data_q  <= grant_id ? bus.req1_data : bus.req0_data;
                        core_key_q   <= grant_id ? bus.req1_key : bus.req0_key;
                        core_valid_q <= 1'b1;
                        state_q      <= StIssue;
                    end
                end
                StIssue: begin
                    state_q <= StWait;
`ifdef AES_ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                StWait: begin
                    if (bus.core_res_valid_in) begin
                        resp_data_q  <= bus.core_res_in;
                        resp_valid_q <= id_to_mask(owner_q);
                        state_q      <= StResp;
`ifdef AES_ARB_TIMEOUT_EN
                        err_q        <= 1'b0;
                    end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                        // Core never answered: report an error with a zeroed block.
                        resp_data_q  <= '0;
                        err_q        <= 1'b1;
                        resp_valid_q <= id_to_mask(owner_q);
                        state_q      <= StResp;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
`endif
                    end
                end
                StResp: begin
                    // Only the owner's ready bit completes the response.
                    if (bus.resp_ready[owner_q]) begin
                        resp_valid_q <= 2'b00;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_enc_arbiter.sv
// Self-checking bench for aes_enc_arbiter. The AES core is a lookup stub with
// programmable latency; expectations come from the round-robin rule and the
// stub's known-answer table.
module tb_aes_enc_arbiter;
    import aes_ctrl_pkg::*;

    localparam block_t FIPS_PT = 128'h3243f6a8885a308d313198a2e0370734;
    localparam block_t FIPS_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam block_t FIPS_CT = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam block_t ZERO_CT = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam block_t ONES    = {128{1'b1}};
    localparam block_t ONES_CT = 128'ha1f6258c877d5fcd8969c964c583d057;

    logic clk;
    logic resetn;
    aes_enc_arbiter_if bus ();

    aes_enc_arbiter #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int      total;
    int      passed;
    int      model_last;
    int      core_lat;
    bit      core_on;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic block_t rand_block();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Core stub: known-answer vectors, otherwise an arbitrary keyed mix.
    function automatic block_t core_fn(input block_t d, input block_t k);
        if (d == FIPS_PT && k == FIPS_K) return FIPS_CT;
        if (d == '0 && k == '0) return ZERO_CT;
        if (d == ONES && k == ONES) return ONES_CT;
        return d ^ {k[63:0], k[127:64]} ^ 128'hc3a5_5a3c_0f1e_e1f0_9669_6996_1234_fedc;
    endfunction

    function automatic logic [1:0] onehot(input int id);
        return (id != 0) ? 2'b10 : 2'b01;
    endfunction

    // Round-robin rule: contention goes to the one not granted last, else the lone one.
    function automatic int rr_pick(input logic [1:0] m, input int last);
        if (m == 2'b11) return 1 - last;
        return m[1] ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Core stub: answers core_valid_out after core_lat cycles, with noise on the bus otherwise.
    initial begin
        block_t res;
        bus.core_res_valid_in = 1'b0;
        bus.core_res_in       = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.core_res_in = rand_block();
            if (bus.core_valid_out && core_on) begin
                res = core_fn(bus.core_data_out, bus.core_key_out);
                repeat (core_lat) @(posedge clk);
                #1;
                bus.core_res_in       = res;
                bus.core_res_valid_in = 1'b1;
                @(posedge clk);
                #1;
                bus.core_res_valid_in = 1'b0;
                bus.core_res_in       = rand_block();
            end
        end
    end

    // Expect an immediate grant to id, then one ISSUE cycle carrying d/k.
    task automatic grant_and_issue(input int id, input block_t d, input block_t k);
        int waited;
        waited = 0;
        @(negedge clk);
        while (bus.req_ready == 2'b00 && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        chk("grant_wait", waited, 0);
        chk("req_ready", bus.req_ready, onehot(id));
        @(posedge clk);
        #1;
        bus.req_valid[id] = 1'b0;
        @(negedge clk);
        chk("issue", {bus.core_valid_out, bus.req_ready, bus.core_data_out, bus.core_key_out},
            {1'b1, 2'b00, d, k});
    endtask

    // Expect the response exp_cyc cycles after acceptance, hold it, then complete it.
    task automatic finish_resp(input int id, input block_t e, input logic err, input int exp_cyc,
                               input int hold);
        int cyc;
        cyc = 2;
        @(negedge clk);
        chk("core_valid_pulse", bus.core_valid_out, 0);
        while (bus.resp_valid == 2'b00 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, exp_cyc);
        chk("resp", {bus.resp_valid, bus.resp_err, bus.resp_data}, {onehot(id), err, e});
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            bus.resp_ready = onehot(1 - id);
            @(negedge clk);
            chk("resp_hold", {bus.resp_valid, bus.resp_err, bus.resp_data, bus.req_ready,
                bus.core_valid_out}, {onehot(id), err, e, 2'b00, 1'b0});
        end
        @(posedge clk);
        #1;
        bus.resp_ready = onehot(id);
        @(posedge clk);
        #1;
        bus.resp_ready = 2'b00;
        chk("resp_release", bus.resp_valid, 2'b00);
    endtask

    // Raise the requests in mask and serve them all in model-predicted order.
    task automatic serve(input logic [1:0] mask, input block_t d0, input block_t k0,
                         input block_t d1, input block_t k1, input block_t e0, input block_t e1,
                         input int hold);
        logic [1:0] pend;
        int         id;
        pend = mask;
        @(posedge clk);
        #1;
        bus.req0_data = d0;
        bus.req0_key  = k0;
        bus.req1_data = d1;
        bus.req1_key  = k1;
        bus.req_valid = mask;
        while (pend != 2'b00) begin
            id = rr_pick(pend, model_last);
            grant_and_issue(id, (id != 0) ? d1 : d0, (id != 0) ? k1 : k0);
            model_last = id;
            pend[id]   = 1'b0;
            finish_resp(id, (id != 0) ? e1 : e0, 1'b0, core_lat + 2, hold);
        end
    endtask

    initial begin
        logic [1:0] m;
        block_t     d0, k0, d1, k1;

        total         = 0;
        passed        = 0;
        model_last    = 1;
        core_lat      = 3;
        core_on       = 1'b1;
        resetn        = 1'b0;
        bus.req_valid = 2'b00;
        bus.resp_ready = 2'b00;
        bus.req0_data = '0;
        bus.req0_key  = '0;
        bus.req1_data = '0;
        bus.req1_key  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", {bus.req_ready, bus.resp_valid, bus.resp_err, bus.core_valid_out}, 0);
        chk("reset_resp_data", bus.resp_data, 0);
        chk("reset_core_bus", {bus.core_data_out, bus.core_key_out}, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // First contention after reset: req0 (FIPS vector) first, then req1 (zeros).
        core_lat = 3;
        serve(2'b11, FIPS_PT, FIPS_K, '0, '0, FIPS_CT, ZERO_CT, 1);
        // Third contention goes back to req0.
        core_lat = 1;
        serve(2'b11, ONES, ONES, '0, '0, ONES_CT, ZERO_CT, 0);

        // Long RESP hold with the non-owner's ready bit set.
        core_lat = 5;
        d1 = rand_block();
        k1 = rand_block();
        serve(2'b10, '0, '0, d1, k1, '0, core_fn(d1, k1), 20);

        for (int n = 0; n < 25; n++) begin
            m        = 2'($urandom_range(1, 3));
            d0       = rand_block();
            k0       = rand_block();
            d1       = rand_block();
            k1       = rand_block();
            core_lat = $urandom_range(1, 8);
            serve(m, d0, k0, d1, k1, core_fn(d0, k0), core_fn(d1, k1), $urandom_range(0, 3));
        end

        // Slow core: 30-cycle result, beyond the 16-cycle timeout when enabled.
        core_lat = 30;
        d0 = rand_block();
        k0 = rand_block();
        @(posedge clk);
        #1;
        bus.req0_data = d0;
        bus.req0_key  = k0;
        bus.req_valid = 2'b01;
        grant_and_issue(0, d0, k0);
        model_last = 0;
`ifdef AES_ARB_TIMEOUT_EN
        finish_resp(0, '0, 1'b1, 18, 2);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("late_result_ignored", {bus.resp_valid, bus.req_ready, bus.core_valid_out}, 0);
        end
`else
        finish_resp(0, core_fn(d0, k0), 1'b0, 32, 0);
`endif

        // Reset asserted while waiting on a silent core.
        core_on = 1'b0;
        d0 = rand_block();
        k0 = rand_block();
        @(posedge clk);
        #1;
        bus.req0_data = d0;
        bus.req0_key  = k0;
        bus.req_valid = 2'b01;
        grant_and_issue(0, d0, k0);
        repeat (4) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("async_reset_ctl", {bus.req_ready, bus.resp_valid, bus.resp_err, bus.core_valid_out},
            0);
        chk("async_reset_resp_data", bus.resp_data, 0);
        chk("async_reset_core_bus", {bus.core_data_out, bus.core_key_out}, 0);
        @(posedge clk);
        #1;
        resetn     = 1'b1;
        model_last = 1;
        core_on    = 1'b1;

        // Lone req1 right after reset is granted without waiting for req0.
        core_lat = 2;
        d1 = rand_block();
        k1 = rand_block();
        serve(2'b10, '0, '0, d1, k1, '0, core_fn(d1, k1), 0);
        serve(2'b01, ONES, ONES, '0, '0, ONES_CT, '0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/aes_enc_arbiter.md
AES_ENC_ARBITER -- requirements
Module: aes_enc_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 1000, the number of WAIT cycles after which the request is aborted (AES_ARB_TIMEOUT_EN only).
REQ-002 clk  in  1  single clock; all logic on posedge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  2  per-requester request valid; bit i belongs to requester i.
REQ-005 req_ready  out  2  per-requester accept strobe; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-006 req0_data / req1_data  in  128  plaintext from each requester.
REQ-007 req0_key / req1_key  in  128  key from each requester.
REQ-008 resp_valid  out  2  per-requester result valid.
REQ-009 resp_ready  in  2  per-requester result accept.
REQ-010 resp_data  out  128  ciphertext, shared by both requesters.
REQ-011 resp_err  out  1  timeout flag, qualified by resp_valid.
REQ-012 core_valid_out  out  1  drives data_valid_in of the AES core.
REQ-013 core_data_out / core_key_out  out  128  drive the core's data_in and key_in.
REQ-014 core_res_in  in  128  connected to the core's res_enc_out.
REQ-015 core_res_valid_in  in  1  connected to the core's res_valid_out.

Function
REQ-016 States: IDLE, ISSUE, WAIT, RESP; exactly one request is outstanding at the core at any time.
REQ-017 IDLE, any req_valid set: grant one requester by round-robin, raise req_ready[grant] for that single cycle, latch data, key and grant ID, then go to ISSUE.
REQ-018 Round-robin: if both requesters are valid, grant the one not granted last; if only one is valid, grant it regardless of history.
REQ-019 req_ready SHALL be 0 in every state other than IDLE.
REQ-020 ISSUE: core_valid_out=1 for exactly one cycle, then go to WAIT.
REQ-021 core_data_out and core_key_out SHALL hold the latched values from ISSUE until the next grant.
REQ-022 WAIT, core_res_valid_in=1: latch core_res_in into resp_data, set resp_err=0, then go to RESP.
REQ-023 core_res_valid_in SHALL be ignored in IDLE, ISSUE and RESP; a late result after a timeout is discarded.
REQ-024 RESP: hold resp_valid[owner]=1 and keep resp_data stable until resp_ready[owner]=1, then go to IDLE.
REQ-025 Minimum turnaround from acceptance to resp_valid is core latency + 2 cycles.
REQ-026 A new grant MAY occur in the cycle after the RESP handshake.
REQ-027 resp_ready[non-owner] SHALL be ignored.

Reset
REQ-028 Assertion of resetn at any time, including mid-WAIT, SHALL force state=IDLE.
REQ-029 On reset: req_ready=0, resp_valid=0, resp_err=0, core_valid_out=0, resp_data=0, core_data_out=0, core_key_out=0, timeout counter=0.
REQ-030 On reset the last-grant pointer SHALL be 1, so requester 0 wins the first contention.

Configuration
REQ-031 With AES_ARB_TIMEOUT_EN defined: a counter clears on WAIT entry and increments each WAIT cycle.
REQ-032 With AES_ARB_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without core_res_valid_in: go to RESP with resp_err=1 and resp_data=0.
REQ-033 Without AES_ARB_TIMEOUT_EN: no counter is present, WAIT is unbounded, and resp_err is tied to 0.

Structure
REQ-034 Package aes_ctrl_pkg SHALL hold the state enum, the requester-ID typedef, the 128-bit block typedef and the default TIMEOUT_CYCLES constant.
REQ-035 The round-robin grant logic SHALL be a sub-module, aes_rr_arbiter, with inputs valid[1:0], last, en and outputs grant_id and grant_vld.

Verification
REQ-036 Requester 0: data 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> resp_valid[0] with 3925841d02dc09fbdc118597196a0b32, resp_err=0.
REQ-037 Both requesters valid in the same cycle (req1 all-zero data and key) -> req0 is served first, then req1 receives 66e94bd4ef8a2c3b884cfa59ca342b2e; a third contention grants req0.
REQ-038 resp_ready held low for 20 cycles in RESP -> resp_valid and resp_data stay stable, req_ready stays 0, and the core sees no second core_valid_out.
REQ-039 Core response stubbed off, AES_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16 -> resp_valid with resp_err=1 sixteen cycles after WAIT entry; a later core_res_valid_in is ignored.
REQ-040 resetn pulsed low during WAIT -> all outputs return to their reset values asynchronously; next request all-ones data and key -> a1f6258c877d5fcd8969c964c583d057.
REQ-041 req1 alone valid after a reset -> req1 is granted immediately, with no wait for req0.
